// File: rtl/minimum_computer_pkg.sv
// rtl/minimum_computer_pkg.sv - shared counter width, trace FSM states and trace entry layout
package minimum_computer_pkg;

    localparam int COUNTER_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } trace_state_t;

    typedef struct packed {
        logic                     wrap;
        logic [COUNTER_WIDTH-1:0] value;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic synchronous show-ahead FIFO with registered head and level
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_next;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign do_pop  = pop & ~empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & (~full | do_pop);
    assign rd_next = do_pop ? rd_ptr + AW'(1) : rd_ptr;

    always_comb begin
        count_next = count;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count + (AW+1)'(1);
            2'b01:   count_next = count - (AW+1)'(1);
            default: count_next = count;
        endcase
    end

    // head is registered so it holds the last shown entry once the FIFO drains
    always_comb begin
        head_next = head;
        if (count_next != '0) begin
            if (do_push && (rd_next == wr_ptr))
                head_next = push_data;
            else
                head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            count <= count_next;
            head  <= head_next;
        end
    end

endmodule

// File: rtl/counter_trace_buffer.sv
// rtl/counter_trace_buffer.sv - records clock_counter changes into a FIFO; TRACE_DROP_COUNT_EN adds drop_count
module counter_trace_buffer
    import minimum_computer_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int COUNTER_WIDTH = minimum_computer_pkg::COUNTER_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [COUNTER_WIDTH-1:0]   counter_in,
    input  logic                       sample_enable,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [COUNTER_WIDTH:0]     out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
`ifdef TRACE_DROP_COUNT_EN
    ,
    output logic [7:0]                 drop_count
`endif
);

    trace_state_t             state;
    trace_state_t             state_next;
    logic [COUNTER_WIDTH-1:0] last;
    logic                     capture;
    logic                     wrap;
    logic                     pop;
    logic                     drop;
    logic                     fifo_full;
    logic                     fifo_empty;
    trace_entry_t             entry;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        wrap       = 1'b0;
        if (!sample_enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:  state_next = PRIME;
                PRIME: begin
                    capture    = 1'b1;
                    state_next = RUN;
                end
                RUN: begin
                    capture = (counter_in != last);
                    wrap    = (counter_in < last);
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign entry.wrap  = wrap;
    assign entry.value = counter_in;
    assign out_valid   = ~fifo_empty;
    assign pop         = out_valid & out_ready;
    assign drop        = capture & fifo_full & ~pop;

    // last tracks capture attempts, so a dropped sample still suppresses its repeats
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last     <= '0;
            overflow <= 1'b0;
        end else begin
            if (capture)
                last <= counter_in;
            if (drop)
                overflow <= 1'b1;
        end
    end

`ifdef TRACE_DROP_COUNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            drop_count <= 8'd0;
        else if (drop && (drop_count != 8'hFF))
            drop_count <= drop_count + 8'd1;
    end
`endif

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (COUNTER_WIDTH + 1)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (capture),
        .push_data (entry),
        .pop       (pop),
        .head      (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

endmodule

// File: tb/tb_counter_trace_buffer.sv
// tb/tb_counter_trace_buffer.sv - scoreboard bench for counter_trace_buffer
module tb_counter_trace_buffer;

    localparam int DEPTH = 8;
    localparam int CW    = 11;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [CW-1:0] counter_in;
    logic          sample_enable;
    logic          out_ready;
    logic          out_valid;
    logic [CW:0]   out_data;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef TRACE_DROP_COUNT_EN
    logic [7:0]    drop_count;
`endif

    counter_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .counter_in    (counter_in),
        .sample_enable (sample_enable),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .level         (level),
        .overflow      (overflow)
`ifdef TRACE_DROP_COUNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    logic [CW:0] exp_q[$];
    int          m_state;
    logic [CW-1:0] m_last;
    logic        m_ovf;
    int          m_drops;
    logic [CW:0] m_hold;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state = 0;
        m_last  = '0;
        m_ovf   = 1'b0;
        m_drops = 0;
        m_hold  = '0;
    endtask

    task automatic do_reset(input logic se, input logic [CW-1:0] cnt);
        sample_enable = se;
        counter_in    = cnt;
        out_ready     = 1'b0;
        reset         = 1'b1;
        model_reset();
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_level",     32'(level),     32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
`ifdef TRACE_DROP_COUNT_EN
        check("rst_drop_count", 32'(drop_count), 32'd0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic cycle(input logic se, input logic [CW-1:0] cnt, input logic rdy);
        logic pop;
        logic cap;
        logic wr;
        sample_enable = se;
        counter_in    = cnt;
        out_ready     = rdy;
        #1;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        check("out_data",  32'(out_data),  32'((exp_q.size() != 0) ? exp_q[0] : m_hold));
        pop = (exp_q.size() != 0) && rdy;
        cap = 1'b0;
        wr  = 1'b0;
        if (se) begin
            if (m_state == 1) begin
                cap = 1'b1;
            end else if (m_state == 2 && cnt != m_last) begin
                cap = 1'b1;
                wr  = (cnt < m_last);
            end
        end
        if (pop)
            m_hold = exp_q.pop_front();
        if (cap) begin
            if (exp_q.size() == DEPTH) begin
                m_ovf = 1'b1;
                if (m_drops < 255)
                    m_drops++;
            end else begin
                exp_q.push_back({wr, cnt});
            end
            m_last = cnt;
        end
        m_state = !se ? 0 : ((m_state == 0) ? 1 : 2);
        @(posedge clock);
        #1;
        check("level",    32'(level),    32'(exp_q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
`ifdef TRACE_DROP_COUNT_EN
        check("drop_count", 32'(drop_count), 32'(m_drops));
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, '0, 1'b1);
        check("drained_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        counter_in    = '0;
        sample_enable = 1'b0;
        out_ready     = 1'b0;
        reset         = 1'b1;

        // reset while armed, first entry is the primed baseline
        do_reset(1'b1, 11'd5);
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 11'd5, 1'b0);
        check("prime_first", 32'(out_data), 32'h005);
        check("prime_level", 32'(level), 32'd1);
        drain();

        // incrementing counter with consumer always ready
        do_reset(1'b0, 11'd0);
        cycle(1'b1, 11'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, CW'(i), 1'b1);
        drain();

        // held value produces a single entry
        do_reset(1'b0, 11'd0);
        cycle(1'b1, 11'd7, 1'b0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 11'd7, 1'b0);
        cycle(1'b1, 11'd8, 1'b0);
        check("hold_level", 32'(level), 32'd2);
        drain();

        // wrap from 2047 to 0
        do_reset(1'b0, 11'd0);
        cycle(1'b1, 11'd2046, 1'b0);
        cycle(1'b1, 11'd2046, 1'b0);
        cycle(1'b1, 11'd2047, 1'b0);
        cycle(1'b1, 11'd0, 1'b0);
        check("wrap_level", 32'(level), 32'd3);
        drain();

        // overflow, then push+pop while full
        do_reset(1'b0, 11'd0);
        cycle(1'b1, 11'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            cycle(1'b1, CW'(i), 1'b0);
        check("ovf_level", 32'(level), 32'd8);
        check("ovf_flag", 32'(overflow), 32'd1);
`ifdef TRACE_DROP_COUNT_EN
        check("ovf_drops", 32'(drop_count), 32'd2);
`endif
        cycle(1'b1, 11'd10, 1'b1);
        check("full_pushpop_level", 32'(level), 32'd8);
        drain();
        check("ovf_sticky", 32'(overflow), 32'd1);

        // reset mid-operation discards entries
        do_reset(1'b0, 11'd0);
        cycle(1'b1, 11'd3, 1'b0);
        cycle(1'b1, 11'd3, 1'b0);
        cycle(1'b1, 11'd4, 1'b0);
        do_reset(1'b0, 11'd0);

        // disarm keeps entries, re-arm primes a fresh baseline
        cycle(1'b1, 11'd0, 1'b0);
        cycle(1'b1, 11'd0, 1'b0);
        cycle(1'b1, 11'd1, 1'b0);
        cycle(1'b1, 11'd2, 1'b0);
        cycle(1'b0, 11'd2, 1'b0);
        check("disarm_level", 32'(level), 32'd3);
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 11'd40, 1'b1);
        check("rearm_last", 32'(out_data), 32'h028);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
